// File: rtl/regfile_wb_if.sv
// Writeback bus between the two requesters, the issue/decode logic and the
// register-file write-port arbiter.
interface regfile_wb_if #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int NUM_REGS = 8
);
  logic                alu_valid;
  logic [ADDR_W-1:0]   alu_dest;
  logic [DATA_W-1:0]   alu_data;
  logic                alu_ready;
  logic                ld_valid;
  logic [ADDR_W-1:0]   ld_dest;
  logic [DATA_W-1:0]   ld_data;
  logic                ld_ready;
  logic                issue_valid;
  logic [ADDR_W-1:0]   issue_dest;
  logic [ADDR_W-1:0]   rs1_ptr;
  logic [ADDR_W-1:0]   rs2_ptr;
  logic                rs1_used;
  logic                rs2_used;
  logic                flush;
  logic                RegWrite;
  logic [ADDR_W-1:0]   Register_Destination;
  logic [DATA_W-1:0]   data_in;
  logic                hazard;
  logic [NUM_REGS-1:0] pend_mask;

  modport master (
    output alu_valid, alu_dest, alu_data, ld_valid, ld_dest, ld_data,
           issue_valid, issue_dest, rs1_ptr, rs2_ptr, rs1_used, rs2_used, flush,
    input  alu_ready, ld_ready, RegWrite, Register_Destination, data_in,
           hazard, pend_mask
  );

  modport slave (
    input  alu_valid, alu_dest, alu_data, ld_valid, ld_dest, ld_data,
           issue_valid, issue_dest, rs1_ptr, rs2_ptr, rs1_used, rs2_used, flush,
    output alu_ready, ld_ready, RegWrite, Register_Destination, data_in,
           hazard, pend_mask
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register-file write port (ALU vs. load path)
// with a registered write stage and a pending-write scoreboard for decode stalls.
//
//   state   | meaning
//   PRI_ALU | ALU path wins when both requesters are valid
//   PRI_LD  | load path wins when both requesters are valid
module regfile_wb_arbiter #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int NUM_REGS = 8
) (
  input logic         clk,
  input logic         rst_n,
  regfile_wb_if.slave bus
);

  typedef enum logic {PRI_ALU = 1'b0, PRI_LD = 1'b1} rr_t;

  rr_t                 rr_q, rr_d;
  logic                alu_gnt, ld_gnt, xfer;
  logic [ADDR_W-1:0]   gnt_dest;
  logic [DATA_W-1:0]   gnt_data;
  logic                reg_write;
  logic [ADDR_W-1:0]   reg_dest;
  logic [DATA_W-1:0]   reg_data;
  logic [NUM_REGS-1:0] pend, pend_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_q <= PRI_ALU;
    else        rr_q <= rr_d;
  end

  // Grants are masked by reset so neither requester sees ready while held in reset.
  always_comb begin
    alu_gnt  = 1'b0;
    ld_gnt   = 1'b0;
    rr_d     = rr_q;
    gnt_dest = bus.alu_dest;
    gnt_data = bus.alu_data;
    if (rst_n) begin
      alu_gnt = bus.alu_valid && (!bus.ld_valid || rr_q == PRI_ALU);
      ld_gnt  = bus.ld_valid && (!bus.alu_valid || rr_q == PRI_LD);
    end
    if (ld_gnt) begin
      gnt_dest = bus.ld_dest;
      gnt_data = bus.ld_data;
    end
    case (rr_q)
      PRI_ALU: if (alu_gnt) rr_d = PRI_LD;
      PRI_LD:  if (ld_gnt)  rr_d = PRI_ALU;
      default: rr_d = PRI_ALU;
    endcase
    if (alu_gnt)     rr_d = PRI_LD;
    else if (ld_gnt) rr_d = PRI_ALU;
  end

  assign xfer = alu_gnt | ld_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write <= 1'b0;
      reg_dest  <= '0;
      reg_data  <= '0;
    end else begin
      reg_write <= xfer;
      if (xfer) begin
        reg_dest <= gnt_dest;
        reg_data <= gnt_data;
      end
    end
  end

  // Issue is applied after the writeback clear so a fresh producer keeps its bit.
  always_comb begin
    pend_d = pend;
    if (reg_write)       pend_d[reg_dest]       = 1'b0;
    if (bus.issue_valid) pend_d[bus.issue_dest] = 1'b1;
    if (bus.flush)       pend_d                 = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= '0;
    else        pend <= pend_d;
  end

  assign bus.alu_ready            = alu_gnt;
  assign bus.ld_ready             = ld_gnt;
  assign bus.RegWrite             = reg_write;
  assign bus.Register_Destination = reg_dest;
  assign bus.data_in              = reg_data;
  assign bus.pend_mask            = pend;
  assign bus.hazard = (bus.rs1_used & pend[bus.rs1_ptr]) |
                      (bus.rs2_used & pend[bus.rs2_ptr]);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: handshake, round-robin, write stage,
// scoreboard and asynchronous reset, with a behavioural register file model.
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  logic [7:0] rf [8];
  int   r2_writes = 0;
  int   r2_before;

  regfile_wb_if #(.DATA_W(8), .ADDR_W(3), .NUM_REGS(8)) bus ();

  regfile_wb_arbiter #(.DATA_W(8), .ADDR_W(3), .NUM_REGS(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.RegWrite) begin
      rf[bus.Register_Destination] <= bus.data_in;
      if (bus.Register_Destination == 3'd2) r2_writes <= r2_writes + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.alu_valid   = 1'b1;
    bus.alu_dest    = 3'd3;
    bus.alu_data    = 8'h5A;
    bus.ld_valid    = 1'b0;
    bus.ld_dest     = 3'd0;
    bus.ld_data     = 8'h00;
    bus.issue_valid = 1'b0;
    bus.issue_dest  = 3'd0;
    bus.rs1_ptr     = 3'd0;
    bus.rs2_ptr     = 3'd0;
    bus.rs1_used    = 1'b0;
    bus.rs2_used    = 1'b0;
    bus.flush       = 1'b0;

    // Reset and single write
    tick();
    tick();
    chk("rst_regwrite", bus.RegWrite, 0);
    chk("rst_dest", bus.Register_Destination, 0);
    chk("rst_data", bus.data_in, 0);
    chk("rst_pend", bus.pend_mask, 0);
    chk("rst_alu_ready", bus.alu_ready, 0);
    chk("rst_ld_ready", bus.ld_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("single_alu_ready", bus.alu_ready, 1);
    tick();
    bus.alu_valid = 1'b0;
    chk("single_regwrite", bus.RegWrite, 1);
    chk("single_dest", bus.Register_Destination, 3);
    chk("single_data", bus.data_in, 8'h5A);
    tick();
    chk("single_regwrite_drop", bus.RegWrite, 0);
    chk("single_dest_hold", bus.Register_Destination, 3);

    // Contention and round-robin, starting from a fresh reset (ALU priority)
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    bus.alu_valid = 1'b1; bus.alu_dest = 3'd1; bus.alu_data = 8'h11;
    bus.ld_valid  = 1'b1; bus.ld_dest  = 3'd2; bus.ld_data  = 8'h22;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr_alu_ready_%0d", i), bus.alu_ready, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("rr_ld_ready_%0d", i), bus.ld_ready, (i % 2 == 1) ? 1 : 0);
      tick();
      chk($sformatf("rr_regwrite_%0d", i), bus.RegWrite, 1);
      chk($sformatf("rr_dest_%0d", i), bus.Register_Destination, (i % 2 == 0) ? 1 : 2);
      chk($sformatf("rr_data_%0d", i), bus.data_in, (i % 2 == 0) ? 8'h11 : 8'h22);
    end
    bus.alu_valid = 1'b0;
    bus.ld_valid  = 1'b0;
    tick();

    // Same destination from both requesters, rr back at ALU priority
    bus.alu_valid = 1'b1; bus.alu_dest = 3'd5; bus.alu_data = 8'hAA;
    bus.ld_valid  = 1'b1; bus.ld_dest  = 3'd5; bus.ld_data  = 8'hBB;
    #1;
    chk("same_alu_first", bus.alu_ready, 1);
    tick();
    bus.alu_valid = 1'b0;
    chk("same_write1_data", bus.data_in, 8'hAA);
    chk("same_write1_dest", bus.Register_Destination, 5);
    #1;
    chk("same_ld_ready", bus.ld_ready, 1);
    tick();
    bus.ld_valid = 1'b0;
    chk("same_write2_en", bus.RegWrite, 1);
    chk("same_write2_data", bus.data_in, 8'hBB);
    tick();
    chk("same_rf_r5", rf[5], 8'hBB);

    // Scoreboard stall on R4
    bus.issue_valid = 1'b1; bus.issue_dest = 3'd4;
    tick();
    bus.issue_valid = 1'b0;
    chk("sb_pend_set", bus.pend_mask, 8'h10);
    bus.rs1_ptr = 3'd4; bus.rs1_used = 1'b0;
    #1;
    chk("sb_unused_no_hazard", bus.hazard, 0);
    bus.rs1_used = 1'b1;
    #1;
    chk("sb_hazard_rs1", bus.hazard, 1);
    tick();
    tick();
    chk("sb_hazard_hold", bus.hazard, 1);
    bus.rs1_used = 1'b0; bus.rs2_ptr = 3'd4; bus.rs2_used = 1'b1;
    #1;
    chk("sb_hazard_rs2", bus.hazard, 1);
    bus.rs2_ptr = 3'd3;
    #1;
    chk("sb_other_reg_clear", bus.hazard, 0);
    bus.rs2_used = 1'b0; bus.rs1_used = 1'b1;
    bus.alu_valid = 1'b1; bus.alu_dest = 3'd4; bus.alu_data = 8'h44;
    tick();
    bus.alu_valid = 1'b0;
    chk("sb_write_r4", bus.Register_Destination, 4);
    chk("sb_hazard_until_write", bus.hazard, 1);
    tick();
    chk("sb_hazard_cleared", bus.hazard, 0);
    chk("sb_pend_cleared", bus.pend_mask, 8'h00);
    bus.rs1_used = 1'b0;

    // Set/clear collision on R6, then flush overriding an issue to R7
    bus.issue_valid = 1'b1; bus.issue_dest = 3'd6;
    bus.alu_valid = 1'b1; bus.alu_dest = 3'd6; bus.alu_data = 8'h66;
    tick();
    bus.alu_valid = 1'b0;
    chk("col_regwrite_r6", bus.RegWrite, 1);
    tick();
    bus.issue_valid = 1'b0;
    chk("col_set_wins", bus.pend_mask, 8'h40);
    bus.flush = 1'b1; bus.issue_valid = 1'b1; bus.issue_dest = 3'd7;
    tick();
    bus.flush = 1'b0; bus.issue_valid = 1'b0;
    chk("flush_pend", bus.pend_mask, 8'h00);

    // Asynchronous reset with a write to R2 sitting in the output stage
    r2_before = r2_writes;
    bus.alu_valid = 1'b1; bus.alu_dest = 3'd2; bus.alu_data = 8'h99;
    bus.issue_valid = 1'b1; bus.issue_dest = 3'd3;
    tick();
    bus.alu_valid = 1'b0; bus.issue_valid = 1'b0;
    chk("ar_inflight", bus.RegWrite, 1);
    chk("ar_pend_before", bus.pend_mask, 8'h08);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_regwrite_async", bus.RegWrite, 0);
    chk("ar_pend_async", bus.pend_mask, 8'h00);
    tick();
    tick();
    chk("ar_r2_not_written", r2_writes, r2_before);
    rst_n = 1'b1;
    bus.alu_valid = 1'b1; bus.alu_dest = 3'd0; bus.alu_data = 8'h01;
    bus.ld_valid  = 1'b1; bus.ld_dest  = 3'd1; bus.ld_data  = 8'h02;
    #1;
    chk("ar_rr_alu_priority", bus.alu_ready, 1);
    chk("ar_rr_ld_blocked", bus.ld_ready, 0);
    tick();
    bus.alu_valid = 1'b0; bus.ld_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the 8x8-bit register file between two writeback requesters: the ALU result path (requester 0) and the memory-load path (requester 1).
- Arbitrates round-robin with a valid/ready handshake and drives the registered write-enable, destination pointer and write data into the register file.
- Keeps an 8-bit pending-write scoreboard so the control FSM can stall an instruction whose source registers still have an outstanding write.

Parameters:
- DATA_W, 8, register data width.
- ADDR_W, 3, register pointer width.
- NUM_REGS, 8, number of registers; must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- alu_valid  input  1  ALU requester has a write pending.
- alu_dest  input  ADDR_W  ALU destination register.
- alu_data  input  DATA_W  ALU write data.
- alu_ready  output  1  ALU request is accepted this cycle.
- ld_valid  input  1  load requester has a write pending.
- ld_dest  input  ADDR_W  load destination register.
- ld_data  input  DATA_W  load write data.
- ld_ready  output  1  load request is accepted this cycle.
- issue_valid  input  1  control FSM issues an instruction that will write issue_dest.
- issue_dest  input  ADDR_W  destination of the issued instruction.
- rs1_ptr  input  ADDR_W  source 1 pointer of the instruction in decode.
- rs2_ptr  input  ADDR_W  source 2 pointer of the instruction in decode.
- rs1_used  input  1  source 1 is actually read.
- rs2_used  input  1  source 2 is actually read.
- flush  input  1  synchronous scoreboard clear.
- RegWrite  output  1  write enable to the register file.
- Register_Destination  output  ADDR_W  write pointer to the register file.
- data_in  output  DATA_W  write data to the register file.
- hazard  output  1  decode must stall.
- pend_mask  output  NUM_REGS  scoreboard contents, one bit per register.

Behaviour:
- Reset:
  - rst_n low asynchronously clears RegWrite, Register_Destination, data_in, pend_mask and the rr pointer.
  - rr = 0 means the ALU has priority.
  - While rst_n is low, alu_ready and ld_ready are 0.
  - Reset mid-operation drops any in-flight write; the register file is not written.
- Requester rules:
  - Once a requester raises valid, it holds valid, dest and data stable until it sees ready high.
  - A transfer happens on a rising edge where valid and ready are both 1.
- Grant (combinational from valid and rr):
  - Only one valid: that requester is granted.
  - Both valid: the requester selected by rr is granted.
  - ready of the granted requester = 1; the other = 0.
  - At most one grant per cycle.
- rr update: on each transfer, rr moves to the non-granted requester. With no transfer, rr holds.
- Bounded wait: a requester holding valid is granted within 2 cycles.
- Output stage (latency 1):
  - The edge that accepts a transfer loads Register_Destination and data_in with the granted dest and data, and sets RegWrite = 1.
  - With no transfer, RegWrite is 0 next cycle and Register_Destination/data_in hold their previous values.
  - The register file captures the write on the following edge, so a read of that register returns the new data 2 edges after the handshake.
  - Back-to-back transfers give RegWrite high on consecutive cycles.
- Scoreboard:
  - pend_mask[issue_dest] is set on the edge where issue_valid = 1.
  - pend_mask[Register_Destination] is cleared on the edge where RegWrite = 1.
  - Set and clear of the same bit on the same edge: set wins, because a new producer is outstanding.
  - flush clears all bits and overrides issue; flush does not cancel a write already in the output stage or alter rr.
- Hazard (combinational): hazard = (rs1_used & pend_mask[rs1_ptr]) | (rs2_used & pend_mask[rs2_ptr]). There is no forwarding.
- Same destination from both requesters in one cycle: serialized in grant order. The later grant's data is the final register value.
- Two issues to the same register before its write: a single pending bit clears on the first write. The control FSM issues at most one in-flight write per register; this is a documented limitation.

Test Plan:
- Reset and single write: rst_n low for 2 cycles, then release; alu_valid=1, alu_dest=3, alu_data=8'h5A. Required: all outputs 0 during reset; alu_ready=1 in the same cycle; next cycle RegWrite=1, Register_Destination=3, data_in=8'h5A; the cycle after, RegWrite=0.
- Contention and round-robin: both requesters valid continuously after reset (ALU dest 1 data 8'h11, load dest 2 data 8'h22). Required grant order: ALU, load, ALU, load. RegWrite stays high every cycle and never drops a request.
- Same destination: both valid with dest 5, ALU data 8'hAA, load data 8'hBB, rr=0. Required: writes appear as 8'hAA then 8'hBB on consecutive cycles; a register file read of R5 afterwards returns 8'hBB.
- Scoreboard stall: issue_valid with issue_dest=4, then rs1_ptr=4, rs1_used=1. Required: hazard=1 until the edge where RegWrite=1 with Register_Destination=4, and 0 after it. The same query with rs1_used=0 gives hazard=0.
- Set/clear collision and flush: issue_dest=6 on the same edge as RegWrite=1 to R6. Required: pend_mask[6] stays 1. Then assert flush together with issue_dest=7. Required: pend_mask=8'h00.
- Asynchronous reset mid-transfer: alu_valid=1, alu_dest=2, then drop rst_n between clock edges. Required: RegWrite, pend_mask and rr go to 0 immediately without a clock edge, and R2 is not written.
